// File: rtl/lsu_mem_initiator_if.sv
// Bundle of the CPU request/response handshakes and the data-memory port used by lsu_mem_initiator.
// master = the initiator block itself, slave = the CPU MEM stage plus data memory around it.
interface lsu_mem_initiator_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              en_mem;
    logic [3:0]        w_en_mem;
    logic [ADDR_W-1:0] addr_mem;
    logic [31:0]       w_data_mem;
    logic [31:0]       r_data_mem;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready, r_data_mem,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output en_mem, w_en_mem, addr_mem, w_data_mem
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready, r_data_mem,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  en_mem, w_en_mem, addr_mem, w_data_mem
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Big-endian load/store initiator for a word-addressed, byte-enabled memory with 1-cycle read latency.
// Define LSU_ALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module lsu_mem_initiator #(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    lsu_mem_initiator_if.master   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    function automatic logic [1:0] align_low(input logic [2:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: align_low = {a[1], 1'b0};
            OP_LW, OP_SW:         align_low = 2'b00;
            default:              align_low = a;
        endcase
    endfunction

    // Lane 0 (lowest byte address) is data[31:24], hence the MSB-first enables.
    function automatic logic [3:0] store_wen(input logic [2:0] op, input logic [1:0] a);
        case (op)
            OP_SB:   store_wen = 4'b1000 >> a;
            OP_SH:   store_wen = a[1] ? 4'b0011 : 4'b1100;
            OP_SW:   store_wen = 4'b1111;
            default: store_wen = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] op, input logic [31:0] wd);
        case (op)
            OP_SB:   store_wdata = {4{wd[7:0]}};
            OP_SH:   store_wdata = {2{wd[15:0]}};
            OP_SW:   store_wdata = wd;
            default: store_wdata = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] a,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = a[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LB:   load_extend = {{24{b[7]}}, b};
            OP_LBU:  load_extend = {24'd0, b};
            OP_LH:   load_extend = {{16{h[15]}}, h};
            OP_LHU:  load_extend = {16'd0, h};
            OP_LW:   load_extend = word;
            default: load_extend = 32'd0;
        endcase
    endfunction

`ifdef LSU_ALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: misaligned = a[0];
            OP_LW, OP_SW:         misaligned = (a != 2'b00);
            default:              misaligned = 1'b0;
        endcase
    endfunction
`endif

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              en_mem_q, en_mem_d;
    logic [3:0]        w_en_mem_q, w_en_mem_d;
    logic [ADDR_W-1:0] addr_mem_q, addr_mem_d;
    logic [31:0]       w_data_mem_q, w_data_mem_d;
    logic              trap_s;
    logic [1:0]        alow_s;

`ifdef LSU_ALIGN_TRAP_EN
    assign trap_s = misaligned(bus.req_op, bus.req_addr[1:0]);
`else
    assign trap_s = 1'b0;
`endif
    assign alow_s = align_low(bus.req_op, bus.req_addr[1:0]);

    // Next-state and next-output logic for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        en_mem_d     = en_mem_q;
        w_en_mem_d   = w_en_mem_q;
        addr_mem_d   = addr_mem_q;
        w_data_mem_d = w_data_mem_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && trap_s) begin
                    state_d     = RESP;
                    req_ready_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                end else if (bus.req_valid) begin
                    state_d      = ISSUE;
                    op_d         = bus.req_op;
                    req_ready_d  = 1'b0;
                    rsp_err_d    = 1'b0;
                    rsp_rdata_d  = 32'd0;
                    en_mem_d     = 1'b1;
                    addr_mem_d   = {bus.req_addr[ADDR_W-1:2], alow_s};
                    w_en_mem_d   = store_wen(bus.req_op, alow_s);
                    w_data_mem_d = store_wdata(bus.req_op, bus.req_wdata);
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                en_mem_d   = 1'b0;
                w_en_mem_d = 4'b0000;
                if (op_q >= OP_SB) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'd0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_extend(op_q, addr_mem_q[1:0], bus.r_data_mem);
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                en_mem_d    = 1'b0;
                w_en_mem_d  = 4'b0000;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 3'd0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            rsp_err_q    <= 1'b0;
            en_mem_q     <= 1'b0;
            w_en_mem_q   <= 4'b0000;
            addr_mem_q   <= {ADDR_W{1'b0}};
            w_data_mem_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            en_mem_q     <= en_mem_d;
            w_en_mem_q   <= w_en_mem_d;
            addr_mem_q   <= addr_mem_d;
            w_data_mem_q <= w_data_mem_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.en_mem     = en_mem_q;
    assign bus.w_en_mem   = w_en_mem_q;
    assign bus.addr_mem   = addr_mem_q;
    assign bus.w_data_mem = w_data_mem_q;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: emulated 1-cycle memory, directed scenarios, then random traffic
// checked against a byte-level reference model of memory and load/store semantics.
module tb_lsu_mem_initiator;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];

    lsu_mem_initiator_if #(.ADDR_W(32)) bus ();

    lsu_mem_initiator #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5C30F1E;
    endfunction

    // Emulated data memory: synchronous read, per-byte writes, reloaded while in reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
            bus.r_data_mem <= 32'd0;
        end else if (bus.en_mem) begin
            if (bus.w_en_mem == 4'd0) begin
                bus.r_data_mem <= tb_mem[bus.addr_mem[9:2]];
            end else begin
                for (int l = 0; l < 4; l++)
                    if (bus.w_en_mem[3-l])
                        tb_mem[bus.addr_mem[9:2]][31-8*l -: 8] <= bus.w_data_mem[31-8*l -: 8];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: big-endian byte memory semantics; also updates ref_mem for stores.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] e_rdata, output logic e_err, output int e_lat,
                         output int e_en, output logic [31:0] e_addr, output logic [3:0] e_wen,
                         output logic [31:0] e_wdata);
        int          size;
        int          off;
        int          lo;
        int          lane;
        bit          st;
        bit          sgn;
        logic [31:0] tmp;
        longint      val;
        size = (op == 3'd0 || op == 3'd1 || op == 3'd5) ? 1 : ((op == 3'd4 || op == 3'd7) ? 4 : 2);
        st   = (op >= 3'd5);
        sgn  = (op == 3'd0 || op == 3'd2);
        off  = int'(addr[1:0]) % size;
        e_rdata = 32'd0; e_err = 1'b0; e_wen = 4'd0; e_wdata = 32'd0; e_addr = 32'd0;
`ifdef LSU_ALIGN_TRAP_EN
        if (off != 0) begin
            e_err = 1'b1; e_lat = 1; e_en = 0;
            return;
        end
`endif
        e_en   = 1;
        e_addr = addr - 32'(off);
        lo     = int'(e_addr[1:0]);
        if (st) begin
            e_lat = 2;
            for (int l = 0; l < 4; l++) begin
                tmp = wdata >> (8 * (size - 1 - (l % size)));
                e_wdata[31-8*l -: 8] = tmp[7:0];
            end
            for (int i = 0; i < size; i++) begin
                lane = lo + i;
                e_wen[3-lane] = 1'b1;
                tmp = wdata >> (8 * (size - 1 - i));
                ref_mem[e_addr[9:2]][31-8*lane -: 8] = tmp[7:0];
            end
        end else begin
            e_lat = 3;
            val = longint'(ref_mem[e_addr[9:2]] >> (8 * (4 - lo - size)));
            val = val & ((longint'(1) << (8 * size)) - 1);
            if (sgn && val >= (longint'(1) << (8 * size - 1))) val = val - (longint'(1) << (8 * size));
            e_rdata = val[31:0];
        end
    endtask

    // One complete transaction with an optional response stall and an ignored request during it.
    task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall, input bit poke, output logic [31:0] rd, output logic er);
        logic [31:0] e_rdata, e_addr, e_wdata, c_addr, c_wdata;
        logic [3:0]  e_wen, c_wen;
        logic        e_err;
        int          e_lat, e_en, k, en_cnt;
        bit          got;
        model(op, addr, wdata, e_rdata, e_err, e_lat, e_en, e_addr, e_wen, e_wdata);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
        cyc();
        bus.req_valid = 1'b0;
        k = 1; en_cnt = 0; got = 1'b0; c_addr = 32'd0; c_wen = 4'd0; c_wdata = 32'd0;
        while (k <= 8 && !got) begin
            if (bus.en_mem) begin
                en_cnt++; c_addr = bus.addr_mem; c_wen = bus.w_en_mem; c_wdata = bus.w_data_mem;
            end
            if (bus.rsp_valid) got = 1'b1;
            else begin cyc(); k++; end
        end
        chk("rsp_arrived", 32'(got), 32'd1);
        chk("latency", 32'(k), 32'(e_lat));
        chk("en_mem_pulses", 32'(en_cnt), 32'(e_en));
        chk("rsp_rdata", bus.rsp_rdata, e_rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
        if (e_en == 1) begin
            chk("addr_mem", c_addr, e_addr);
            chk("w_en_mem", 32'(c_wen), 32'(e_wen));
            if (op >= 3'd5) chk("w_data_mem", c_wdata, e_wdata);
        end
        rd = bus.rsp_rdata; er = bus.rsp_err;
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                bus.req_valid = 1'b1; bus.req_op = 3'd7; bus.req_addr = addr + 32'd4;
                bus.req_wdata = 32'hBAD0BAD0;
            end
            cyc();
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_rdata", bus.rsp_rdata, rd);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_en_mem", 32'(bus.en_mem), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("req_ready_back", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd, e_rdata, e_addr, e_wdata, got_rd;
        logic [3:0]  e_wen;
        logic        er, e_err;
        int          e_lat, e_en, n_acc;
        int          acc_edge [2];
        bit          acc, got;
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b0;
        ref_init();
        cyc(); cyc();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_en_mem", 32'(bus.en_mem), 32'd0);
        chk("rst_w_en_mem", 32'(bus.w_en_mem), 32'd0);
        chk("rst_addr_mem", bus.addr_mem, 32'd0);
        chk("rst_w_data_mem", bus.w_data_mem, 32'd0);
        rst = 1'b0;
        cyc();

        // Reset asserted in the middle of the ISSUE cycle of a SW.
        bus.req_valid = 1'b1; bus.req_op = 3'd7; bus.req_addr = 32'h80; bus.req_wdata = 32'h11223344;
        cyc();
        bus.req_valid = 1'b0;
        chk("t1_issue_en", 32'(bus.en_mem), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_en_mem", 32'(bus.en_mem), 32'd0);
        chk("t1_rst_w_en", 32'(bus.w_en_mem), 32'd0);
        chk("t1_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        cyc();
        rst = 1'b0;
        ref_init();
        chk("t1_req_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("t1_no_en", 32'(bus.en_mem), 32'd0);
        end

        // SB into lane 2.
        do_txn(3'd5, 32'h102, 32'h000000A5, 0, 1'b0, rd, er);
        chk("t2_sb_rdata", rd, 32'd0);

        // Sign/zero extension of each lane of a known word.
        do_txn(3'd7, 32'h200, 32'h80FF7F01, 0, 1'b0, rd, er);
        do_txn(3'd0, 32'h200, 32'd0, 0, 1'b0, rd, er);
        chk("t3_lb", rd, 32'hFFFFFF80);
        do_txn(3'd1, 32'h201, 32'd0, 0, 1'b0, rd, er);
        chk("t3_lbu", rd, 32'h000000FF);
        do_txn(3'd2, 32'h202, 32'd0, 0, 1'b0, rd, er);
        chk("t3_lh", rd, 32'h00007F01);
        do_txn(3'd3, 32'h200, 32'd0, 1, 1'b0, rd, er);
        chk("t3_lhu", rd, 32'h000080FF);

        // LW with a 5-cycle response stall and an ignored SW request during it.
        do_txn(3'd4, 32'h300, 32'd0, 5, 1'b1, rd, er);
        do_txn(3'd4, 32'h304, 32'd0, 0, 1'b0, rd, er);
        chk("t4_poke_ignored", rd, init_word(32'h304 >> 2));

        // Misaligned SH.
        do_txn(3'd6, 32'h101, 32'h00001234, 0, 1'b0, rd, er);
`ifdef LSU_ALIGN_TRAP_EN
        chk("t5_trap_err", 32'(er), 32'd1);
`else
        chk("t5_noerr", 32'(er), 32'd0);
        do_txn(3'd4, 32'h100, 32'd0, 0, 1'b0, rd, er);
        chk("t5_halfword_written", rd[31:16], 32'h1234);
`endif

        // Back-to-back SW then LW with rsp_ready held high.
        model(3'd7, 32'h40, 32'hDEADBEEF, e_rdata, e_err, e_lat, e_en, e_addr, e_wen, e_wdata);
        model(3'd4, 32'h40, 32'd0, e_rdata, e_err, e_lat, e_en, e_addr, e_wen, e_wdata);
        bus.req_valid = 1'b1; bus.req_op = 3'd7; bus.req_addr = 32'h40; bus.req_wdata = 32'hDEADBEEF;
        bus.rsp_ready = 1'b1;
        n_acc = 0; got = 1'b0; got_rd = 32'd0; acc_edge[0] = 0; acc_edge[1] = 0;
        for (int c = 1; c <= 12; c++) begin
            acc = bus.req_ready && bus.req_valid;
            cyc();
            if (acc && n_acc < 2) begin
                acc_edge[n_acc] = c;
                n_acc++;
                if (n_acc == 1) bus.req_op = 3'd4;
                else bus.req_valid = 1'b0;
            end
            if (n_acc == 2 && bus.rsp_valid && !got) begin
                got = 1'b1; got_rd = bus.rsp_rdata;
            end
        end
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        chk("t6_two_accepts", 32'(n_acc), 32'd2);
        chk("t6_accept_gap", 32'(acc_edge[1] - acc_edge[0]), 32'd3);
        chk("t6_load_rsp", 32'(got), 32'd1);
        chk("t6_load_data", got_rd, 32'hDEADBEEF);
        chk("t6_load_model", got_rd, e_rdata);
        cyc();

        // Random traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            do_txn(3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)), $urandom,
                   $urandom_range(0, 2), 1'b0, rd, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
